// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU operand sequencer: FSM state
// encoding, ALU funct3 / compare select codes and default bus widths.
package alu_seq_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD1  = 3'd1,
    RD2  = 3'd2,
    EXEC = 3'd3,
    WB   = 3'd4,
    DONE = 3'd5
  } seq_state_t;

  // Arithmetic / logic select
  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SUB = 3'd1;
  localparam logic [2:0] F3_XOR = 3'd2;
  localparam logic [2:0] F3_OR  = 3'd3;
  localparam logic [2:0] F3_AND = 3'd4;
  localparam logic [2:0] F3_SLL = 3'd5;
  localparam logic [2:0] F3_SRL = 3'd6;
  localparam logic [2:0] F3_SRA = 3'd7;

  // Compare select: 0..3 signed, 4..7 the unsigned counterparts
  localparam logic [2:0] CMP_EQ  = 3'd0;
  localparam logic [2:0] CMP_NE  = 3'd1;
  localparam logic [2:0] CMP_LT  = 3'd2;
  localparam logic [2:0] CMP_GE  = 3'd3;
  localparam logic [2:0] CMP_EQU = 3'd4;
  localparam logic [2:0] CMP_NEU = 3'd5;
  localparam logic [2:0] CMP_LTU = 3'd6;
  localparam logic [2:0] CMP_GEU = 3'd7;

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Memory-side request bus of the operand sequencer. The sequencer drives
// address/strobes/write data (master); the memory returns read data and
// the ready that completes the pending strobe (slave).
interface alu_operand_sequencer_if
  import alu_seq_pkg::*;
();

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata, mem_ready
  );

endinterface

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle operand sequencer for the memory-memory datapath: reads two
// operands, hands them to the external ALU, captures the result/compare
// flag and writes the result back unless in compare mode.
//
// Optional build macro SEQ_SRC_FORWARD_EN: when both source addresses match
// at accept, the single RD1 read feeds both operands and RD2 is skipped.
//
// state | meaning
// IDLE  | waiting for start, latches request fields on accept
// RD1   | read src1 into alu_A
// RD2   | read src2 into alu_B
// EXEC  | one cycle, capture ALU result and compare flag
// WB    | write result to dst (skipped in compare mode)
// DONE  | one-cycle done pulse, back to IDLE
module alu_operand_sequencer
  import alu_seq_pkg::*;
(
  input  logic                      CLK,
  input  logic                      reset,       // active-low, asynchronous
  input  logic                      start,
  input  logic [2:0]                funct3,
  input  logic                      cmp_mode,
  input  logic [ADDR_W-1:0]         src1_addr,
  input  logic [ADDR_W-1:0]         src2_addr,
  input  logic [ADDR_W-1:0]         dst_addr,
  alu_operand_sequencer_if.master   mem,
  output logic [2:0]                alu_funct3,
  output logic [DATA_W-1:0]         alu_A,
  output logic [DATA_W-1:0]         alu_B,
  input  logic [DATA_W-1:0]         alu_out,
  input  logic                      alu_cmp,
  output logic [DATA_W-1:0]         result,
  output logic                      cmp_flag,
  output logic                      busy,
  output logic                      done
);

  seq_state_t        state_q, state_d;
  logic              cmp_mode_q;
  logic [ADDR_W-1:0] src1_q, src2_q, dst_q;
`ifdef SEQ_SRC_FORWARD_EN
  logic              same_src_q;
`endif

  // State register; reset drops every strobe immediately since they decode from state
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state decode and memory/control outputs
  always_comb begin
    state_d       = state_q;
    mem.mem_rd    = 1'b0;
    mem.mem_wr    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    busy          = (state_q != IDLE);
    done          = (state_q == DONE);
    case (state_q)
      IDLE: if (start) state_d = RD1;
      RD1: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = src1_q;
`ifdef SEQ_SRC_FORWARD_EN
        if (mem.mem_ready) state_d = same_src_q ? EXEC : RD2;
`else
        if (mem.mem_ready) state_d = RD2;
`endif
      end
      RD2: begin
        mem.mem_rd   = 1'b1;
        mem.mem_addr = src2_q;
        if (mem.mem_ready) state_d = EXEC;
      end
      EXEC: state_d = cmp_mode_q ? DONE : WB;
      WB: begin
        mem.mem_wr    = 1'b1;
        mem.mem_addr  = dst_q;
        mem.mem_wdata = result;
        if (mem.mem_ready) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, operand capture and result capture
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      cmp_mode_q <= 1'b0;
      src1_q     <= '0;
      src2_q     <= '0;
      dst_q      <= '0;
      alu_funct3 <= '0;
      alu_A      <= '0;
      alu_B      <= '0;
      result     <= '0;
      cmp_flag   <= 1'b0;
`ifdef SEQ_SRC_FORWARD_EN
      same_src_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (start) begin
          cmp_mode_q <= cmp_mode;
          src1_q     <= src1_addr;
          src2_q     <= src2_addr;
          dst_q      <= dst_addr;
          alu_funct3 <= funct3;
`ifdef SEQ_SRC_FORWARD_EN
          same_src_q <= (src1_addr == src2_addr);
`endif
        end
        RD1: if (mem.mem_ready) begin
          alu_A <= mem.mem_rdata;
`ifdef SEQ_SRC_FORWARD_EN
          if (same_src_q) alu_B <= mem.mem_rdata;
`endif
        end
        RD2: if (mem.mem_ready) alu_B <= mem.mem_rdata;
        EXEC: begin
          result   <= alu_out;
          cmp_flag <= alu_cmp;
        end
        default: ;
      endcase
    end
  end

endmodule
